// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: carries one opaque payload between
// two stages, honouring the shared stall vector (hold or bubble), a
// valid/ready handshake, synchronous flush, an optional 1-entry skid buffer
// and a saturating count of inserted bubbles.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH     = 110,
  parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
  parameter int unsigned       STALL_W   = 6,
  parameter int unsigned       STAGE     = 3,
  parameter bit                SKID      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [15:0]        bubble_cnt
);

  // Main register M and skid register S
  logic             r_mv;
  logic [WIDTH-1:0] r_md;
  logic             r_sv;
  logic [WIDTH-1:0] r_sd;
  logic             r_in_ready;
  logic [15:0]      r_bubble_cnt;

  logic             w_up_stop;
  logic             w_dn_stop;
  logic             w_m_load;
  logic             w_take;
  logic             w_bubble;
  logic             w_nmv;
  logic [WIDTH-1:0] w_nmd;
  logic             w_nsv;
  logic [WIDTH-1:0] w_nsd;
  logic             w_unused_stall;

  assign w_up_stop      = stall[STAGE];
  assign w_dn_stop      = stall[STAGE+1];
  assign w_unused_stall = ^stall;

  assign w_m_load = !w_dn_stop && (!r_mv || out_ready);
  assign in_ready = SKID ? r_in_ready : w_m_load;
  assign w_take   = in_valid && in_ready && !w_up_stop;

  // A bubble is counted only when M actually takes an empty slot from upstream
  assign w_bubble = !flush && w_m_load && !r_sv && w_up_stop;

  assign out_valid  = r_mv;
  assign out_data   = r_md;
  assign bubble_cnt = r_bubble_cnt;

  // Next-state selection for M and S: flush, then drain/refill of M, else skid capture
  always_comb begin
    w_nmv = r_mv;
    w_nmd = r_md;
    w_nsv = r_sv;
    w_nsd = r_sd;
    if (flush) begin
      w_nmv = 1'b0;
      w_nmd = NOP_VALUE;
      w_nsv = 1'b0;
      w_nsd = NOP_VALUE;
    end else if (w_m_load) begin
      if (r_sv) begin
        w_nmv = 1'b1;
        w_nmd = r_sd;
        if (w_take) begin
          w_nsv = 1'b1;
          w_nsd = in_data;
        end else begin
          w_nsv = 1'b0;
          w_nsd = NOP_VALUE;
        end
      end else if (w_take) begin
        w_nmv = 1'b1;
        w_nmd = in_data;
      end else begin
        w_nmv = 1'b0;
        w_nmd = NOP_VALUE;
      end
    end else if (SKID && w_take) begin
      w_nsv = 1'b1;
      w_nsd = in_data;
    end
  end

  // State registers; in_ready is kept as its own flop so it leaves the block unbuffered by logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mv       <= 1'b0;
      r_md       <= NOP_VALUE;
      r_sv       <= 1'b0;
      r_sd       <= NOP_VALUE;
      r_in_ready <= 1'b1;
    end else begin
      r_mv       <= w_nmv;
      r_md       <= w_nmd;
      r_sv       <= w_nsv;
      r_sd       <= w_nsd;
      r_in_ready <= !w_nsv;
    end
  end

  // Saturating bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted payloads are queued when
// driven and compared in order as the stage hands them downstream.
module tb_pipe_stage_reg;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [15:0]  bubble_cnt;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH    (W),
    .NOP_VALUE('0),
    .STALL_W  (6),
    .STAGE    (3),
    .SKID     (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Downstream monitor: empty slots must show NOP, real transfers pop the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid) chk("nop_data", 32'(out_data), 32'h0);
      if (out_valid && out_ready && !stall[4] && !flush) begin
        chk("q_nonempty", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_cnt", 32'(bubble_cnt), 32'h0);
    rst = 1'b0;
    step();

    // Streaming: one-cycle latency, back to back
    for (int v = 1; v <= 3; v++) begin
      in_valid = 1'b1; in_data = W'(v); exp_q.push_back(W'(v));
      step();
      chk("stream_valid", 32'(out_valid), 32'h1);
      chk("stream_data", 32'(out_data), 32'(v));
    end
    in_valid = 1'b0;
    step();

    // Bubble: upstream stopped, downstream running
    in_valid = 1'b1; in_data = 16'd7; stall = 6'b001000;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bubble_valid", 32'(out_valid), 32'h0);
      chk("bubble_data", 32'(out_data), 32'h0);
    end
    chk("bubble_cnt2", 32'(bubble_cnt), 32'h2);
    stall = '0; exp_q.push_back(16'd7);
    step();
    chk("after_bubble", 32'(out_data), 32'h7);
    in_valid = 1'b0;
    step();
    chk("delivered_once", 32'(out_valid), 32'h0);

    // Backpressure into skid buffer
    in_valid = 1'b1; in_data = 16'd5; exp_q.push_back(16'd5);
    step();
    out_ready = 1'b0; in_data = 16'd6; exp_q.push_back(16'd6);
    step();
    chk("skid_full_ready", 32'(in_ready), 32'h0);
    in_data = 16'd7; exp_q.push_back(16'd7);
    step();
    chk("skid_hold_ready", 32'(in_ready), 32'h0);
    chk("skid_hold_data", 32'(out_data), 32'h5);
    out_ready = 1'b1;
    step();
    chk("skid_drain_data", 32'(out_data), 32'h6);
    chk("skid_drain_ready", 32'(in_ready), 32'h1);
    step();
    chk("skid_last_data", 32'(out_data), 32'h7);
    in_valid = 1'b0;
    step();

    // Flush drops M, S and the same-cycle offer
    in_valid = 1'b1; in_data = 16'd9;
    step();
    out_ready = 1'b0; in_data = 16'd10;
    step();
    in_data = 16'd11; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);
    chk("flush_cnt", 32'(bubble_cnt), 32'h2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_flush_valid", 32'(out_valid), 32'h0);
    end

    // Asynchronous reset mid-transfer with M and S both full
    in_valid = 1'b1; in_data = 16'd20; exp_q.push_back(16'd20);
    step();
    out_ready = 1'b0; in_data = 16'd21;
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_data", 32'(out_data), 32'h0);
    chk("async_rst_ready", 32'(in_ready), 32'h1);
    chk("async_rst_cnt", 32'(bubble_cnt), 32'h0);
    exp_q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Saturation of the bubble counter
    stall = 6'b001000;
    repeat (65534) step();
    chk("cnt_fffe", 32'(bubble_cnt), 32'hFFFE);
    repeat (6) step();
    chk("cnt_sat", 32'(bubble_cnt), 32'hFFFF);

    // Hold when both sides stopped
    stall = '0; in_valid = 1'b1; in_data = 16'd4; exp_q.push_back(16'd4);
    step();
    in_valid = 1'b0; stall = 6'b011000;
    repeat (3) step();
    chk("hold_valid", 32'(out_valid), 32'h1);
    chk("hold_data", 32'(out_data), 32'h4);
    chk("hold_cnt", 32'(bubble_cnt), 32'hFFFF);
    stall = '0;
    step();
    step();
    chk("q_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
